cdb_scheduler: RTL and testbench
================================

Name: cdb_scheduler

Overview:
Round-robin scheduler that shares the single Common Data Bus (CDB) between N functional units / reservation stations in the Tomasulo core.
- Each requester gets a one-entry holding slot, so a functional unit is released as soon as its result is captured, not when the bus is free.
- Sits between the functional units (Done/Q/tag) and the CDB consumers: register_status, reservation stations and seletor_uf (via Qi_CDB/Qi_CDB_data).
- Drives a one-hot Finished vector so the owning station clears Busy.

Parameters:
- N_REQ, 2, number of requesters (ADD1, ADD2, …); legal range 2..8.
- DATA_W, 16, result width.
- TAG_W, 4, reservation-station tag width; tag 0 = FREE_REGISTER (no producer).
- SEM_VALOR, 16'hFFF0, data value driven on an idle bus.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high.
- Done  in  N_REQ  per-requester result-valid; held until Ack.
- Tag  in  N_REQ*TAG_W  flattened producing-station tag; requester i occupies bits [i*TAG_W +: TAG_W].
- Q  in  N_REQ*DATA_W  flattened result data; same packing as Tag.
- Ack  out  N_REQ  combinational; result captured at this clock edge.
- Qi_CDB  out  TAG_W  broadcast tag; 0 when idle.
- Qi_CDB_data  out  DATA_W  broadcast data; SEM_VALOR when idle.
- CDB_Valid  out  1  broadcast valid, one cycle per result.
- Finished  out  N_REQ  one-hot of the requester whose result is on the bus; aligned with CDB_Valid.
- Pending  out  clog2(N_REQ+1)  count of occupied holding slots.
- Tag_Err  out  1  sticky; a Done with Tag==0 was seen.

Behaviour:
- Clocking and reset: one clock domain; Reset is synchronous and active-high; all state updates on posedge Clock.
- Reset values: slots empty; rr_ptr=0; CDB_Valid=0; Qi_CDB=0; Qi_CDB_data=SEM_VALOR; Finished=0; Pending=0; Tag_Err=0.
- Ack forced to 0 while Reset=1. Reset mid-operation drops every held result, with no broadcast.
- Capture: Ack_i = Done_i & (Tag_i!=0) & (slot_i empty | slot_i granted this cycle) & !Reset.
  - On Ack_i, slot_i loads {Tag_i, Q_i} at the edge.
  - The requester drops Done or presents new data in the next cycle.
- Invalid tag: Done_i with Tag_i==0 is never acked, sets Tag_Err (cleared only by Reset), and never reaches the bus.
- Arbitration (combinational):
  - Grant the first valid slot found searching from rr_ptr upward, with modulo-N_REQ wrap.
  - On a grant to k, rr_ptr <= (k+1) mod N_REQ. rr_ptr is unchanged when no slot is valid.
- Broadcast: the registered output stage loads the granted slot, so CDB_Valid=1, Qi_CDB=tag, Qi_CDB_data=data and Finished=1<<k all appear the following cycle.
  - With no grant: CDB_Valid=0, Qi_CDB=0, data=SEM_VALOR, Finished=0.
- Slot release: a granted slot is cleared at the same edge unless simultaneously refilled (bypass refill). One requester can therefore stream one result per cycle with no bubble.
- Latency: Done_i seen in cycle t with bus idle → Ack_i in t → slot valid t+1 → CDB_Valid in t+2. Throughput: one broadcast per cycle.
- Fairness: any valid slot is granted within N_REQ cycles.
- At most one broadcast per cycle, and Finished is always one-hot or zero.
- Pending = popcount of valid slots after each edge.
- All requesters done in the same cycle: all are acked; broadcasts are serialized in round-robin order.

Decomposition:
- tomasulo_pkg holds:
  - DATA_W, TAG_W, SEM_VALOR;
  - station codes FREE_REGISTER=0, RES_STATION_ADD1=1, RES_STATION_ADD2=2;
  - a cdb_slot_t {valid, tag, data} struct/typedef.
- Sub-module rr_arbiter (parameter N): request vector in; one-hot grant and grant-valid out; owns the rr_ptr register. Shared later by the issue-port arbiter.

Test Plan:
1. Single result: reset, then Done[0]=1, Tag0=1, Q0=0x0005 in cycle 1 → Ack[0]=1 in cycle 1; cycle 3 shows CDB_Valid=1, Qi_CDB=1, data=0x0005, Finished=01; cycle 4 returns to Qi_CDB=0, data=0xFFF0.
2. Simultaneous requests: Done[0] (tag1, 0x0011) and Done[1] (tag2, 0x0022) in the same cycle → both acked; broadcasts are tag1 then tag2 on consecutive cycles; Pending goes 2→1→0.
3. Streaming: Done[0] held 3 cycles with Q=0x0001/0x0002/0x0003 → Ack every cycle; three consecutive broadcasts in that order, no bubble.
4. Fairness: both requesters saturated for 8 cycles → bus alternates tag1/tag2, 4 broadcasts each; no two consecutive grants to the same requester.
5. Bad tag: Done[1]=1 with Tag1=0 → Ack[1]=0, Tag_Err=1 and stays 1, no CDB_Valid; only Reset clears Tag_Err.
6. Reset mid-operation: both slots full, Reset=1 for one cycle → next cycle CDB_Valid=0, Pending=0, Finished=0, Ack=0 during Reset; held results are never broadcast.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core types: bus widths, the idle-bus data value,
// reservation-station codes and the CDB holding-slot record.
package tomasulo_pkg;

  localparam int DATA_W = 16;
  localparam int TAG_W  = 4;
  localparam logic [DATA_W-1:0] SEM_VALOR = 16'hFFF0;

  // Tag 0 means "no producer", so it can never be broadcast.
  typedef enum logic [TAG_W-1:0] {
    FREE_REGISTER    = 4'd0,
    RES_STATION_ADD1 = 4'd1,
    RES_STATION_ADD2 = 4'd2
  } station_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_slot_t;

endpackage

// File: rtl/cdb_scheduler_if.sv
// Requester/broadcast bundle between functional units and the CDB scheduler.
interface cdb_scheduler_if import tomasulo_pkg::*; #(parameter int N_REQ = 2);

  localparam int PEND_W = $clog2(N_REQ + 1);

  logic [N_REQ-1:0]        Done;
  logic [N_REQ*TAG_W-1:0]  Tag;
  logic [N_REQ*DATA_W-1:0] Q;
  logic [N_REQ-1:0]        Ack;
  logic [TAG_W-1:0]        Qi_CDB;
  logic [DATA_W-1:0]       Qi_CDB_data;
  logic                    CDB_Valid;
  logic [N_REQ-1:0]        Finished;
  logic [PEND_W-1:0]       Pending;
  logic                    Tag_Err;

  modport master (
    output Done, Tag, Q,
    input  Ack, Qi_CDB, Qi_CDB_data, CDB_Valid, Finished, Pending, Tag_Err
  );

  modport slave (
    input  Done, Tag, Q,
    output Ack, Qi_CDB, Qi_CDB_data, CDB_Valid, Finished, Pending, Tag_Err
  );

endinterface

// File: rtl/cdb_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or above the pointer,
// wrapping modulo N, then moves the pointer just past the winner.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         srst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         grant_valid
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W:0]   idx;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    ptr_d       = ptr_q;
    idx         = '0;
    for (int off = 0; off < N; off++) begin
      idx = {1'b0, ptr_q} + (PTR_W+1)'(off);
      if (idx >= (PTR_W+1)'(N)) begin
        idx = idx - (PTR_W+1)'(N);
      end
      if (!grant_valid && req[idx[PTR_W-1:0]]) begin
        grant[idx[PTR_W-1:0]] = 1'b1;
        grant_valid           = 1'b1;
        ptr_d = (idx == (PTR_W+1)'(N-1)) ? '0 : idx[PTR_W-1:0] + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/cdb_scheduler.sv
// Shares the Common Data Bus among N_REQ functional units: one holding slot
// per requester, round-robin grant, registered broadcast stage.
module cdb_scheduler import tomasulo_pkg::*; #(
  parameter int N_REQ = 2
) (
  input  logic           Clock,
  input  logic           Reset,
  cdb_scheduler_if.slave bus
);

  localparam int PEND_W = $clog2(N_REQ + 1);

  logic [N_REQ-1:0]        slot_valid;
  logic [N_REQ*TAG_W-1:0]  slot_tag;
  logic [N_REQ*DATA_W-1:0] slot_data;
  logic [N_REQ-1:0]        grant, ack, bad_tag;
  logic                    grant_valid;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk         (Clock),
    .srst        (Reset),
    .req         (slot_valid),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
    cdb_slot_t        slot_q, slot_d;
    logic [TAG_W-1:0] req_tag;

    assign req_tag     = bus.Tag[gi*TAG_W +: TAG_W];
    assign bad_tag[gi] = bus.Done[gi] && (req_tag == FREE_REGISTER);
    // A granted slot may be refilled at the same edge it is drained.
    assign ack[gi] = bus.Done[gi] && (req_tag != FREE_REGISTER) &&
                     (!slot_q.valid || grant[gi]) && !Reset;

    assign slot_valid[gi]                  = slot_q.valid;
    assign slot_tag[gi*TAG_W +: TAG_W]     = slot_q.tag;
    assign slot_data[gi*DATA_W +: DATA_W]  = slot_q.data;

    always_comb begin
      slot_d = slot_q;
      if (ack[gi]) begin
        slot_d = '{valid: 1'b1, tag: req_tag, data: bus.Q[gi*DATA_W +: DATA_W]};
      end else if (grant[gi]) begin
        slot_d = '0;
      end
    end

    always_ff @(posedge Clock) begin
      if (Reset) begin
        slot_q <= '0;
      end else begin
        slot_q <= slot_d;
      end
    end
  end

  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  qi_cdb_q, qi_cdb_d;
  logic [DATA_W-1:0] qi_data_q, qi_data_d;
  logic [N_REQ-1:0]  finished_q, finished_d;
  logic              tag_err_q, tag_err_d;
  logic [PEND_W-1:0] pending;

  always_comb begin
    cdb_valid_d = 1'b0;
    qi_cdb_d    = '0;
    qi_data_d   = SEM_VALOR;
    finished_d  = '0;
    if (grant_valid) begin
      cdb_valid_d = 1'b1;
      finished_d  = grant;
      for (int i = 0; i < N_REQ; i++) begin
        if (grant[i]) begin
          qi_cdb_d  = slot_tag[i*TAG_W +: TAG_W];
          qi_data_d = slot_data[i*DATA_W +: DATA_W];
        end
      end
    end
    tag_err_d = tag_err_q || (|bad_tag);
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pending = pending + PEND_W'(slot_valid[i]);
    end
  end

  // Reset also suppresses the broadcast of whatever was granted this cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cdb_valid_q <= 1'b0;
      qi_cdb_q    <= '0;
      qi_data_q   <= SEM_VALOR;
      finished_q  <= '0;
      tag_err_q   <= 1'b0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      qi_cdb_q    <= qi_cdb_d;
      qi_data_q   <= qi_data_d;
      finished_q  <= finished_d;
      tag_err_q   <= tag_err_d;
    end
  end

  assign bus.Ack         = ack;
  assign bus.CDB_Valid   = cdb_valid_q;
  assign bus.Qi_CDB      = qi_cdb_q;
  assign bus.Qi_CDB_data = qi_data_q;
  assign bus.Finished    = finished_q;
  assign bus.Pending     = pending;
  assign bus.Tag_Err     = tag_err_q;

endmodule

// File: tb/tb_cdb_scheduler.sv
// Scoreboard bench for cdb_scheduler: stimulus pushes expected broadcasts,
// a negedge monitor pops and compares them against the bus.
module tb_cdb_scheduler;
  import tomasulo_pkg::*;

  localparam int N = 2;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  cdb_scheduler_if #(.N_REQ(N)) bus();

  cdb_scheduler #(.N_REQ(N)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [3:0]  tag;
    logic [15:0] data;
    logic [1:0]  fin;
  } exp_t;

  exp_t q_exp[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Drives one cycle of requests (called at posedge+1), checks Ack, queues
  // the expected broadcasts in index order, and advances to next posedge+1.
  task automatic cyc(input logic [1:0] done,
                     input logic [3:0] t0, input logic [15:0] q0,
                     input logic [3:0] t1, input logic [15:0] q1,
                     input logic [1:0] exp_ack, input bit push);
    exp_t e;
    bus.Done = done;
    bus.Tag  = {t1, t0};
    bus.Q    = {q1, q0};
    #1;
    check("ack", 32'(bus.Ack), 32'(exp_ack));
    if (push && exp_ack[0]) begin
      e.tag = t0; e.data = q0; e.fin = 2'b01;
      q_exp.push_back(e);
    end
    if (push && exp_ack[1]) begin
      e.tag = t1; e.data = q1; e.fin = 2'b10;
      q_exp.push_back(e);
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(2'b00, 4'd0, 16'd0, 4'd0, 16'd0, 2'b00, 1'b0);
  endtask

  task automatic reset_dut();
    Reset = 1'b1;
    cyc(2'b00, 4'd0, 16'd0, 4'd0, 16'd0, 2'b00, 1'b0);
    Reset = 1'b0;
  endtask

  always @(negedge Clock) begin
    exp_t e;
    if (mon_en) begin
      if (bus.CDB_Valid) begin
        if (q_exp.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_bcast actual tag=%h data=%h required=no broadcast",
                   bus.Qi_CDB, bus.Qi_CDB_data);
        end else begin
          e = q_exp.pop_front();
          $display("bcast t=%0t tag=%h data=%h fin=%b", $time, bus.Qi_CDB, bus.Qi_CDB_data, bus.Finished);
          check("bcast_tag",  32'(bus.Qi_CDB),      32'(e.tag));
          check("bcast_data", 32'(bus.Qi_CDB_data), 32'(e.data));
          check("bcast_fin",  32'(bus.Finished),    32'(e.fin));
        end
      end else begin
        check("idle_tag",  32'(bus.Qi_CDB),      32'd0);
        check("idle_data", 32'(bus.Qi_CDB_data), 32'(SEM_VALOR));
        check("idle_fin",  32'(bus.Finished),    32'd0);
      end
    end
  end

  initial begin
    int na;
    int nb;
    logic [1:0] ea;
    bus.Done = '0;
    bus.Tag  = '0;
    bus.Q    = '0;
    Reset    = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
    check("rst_valid",   32'(bus.CDB_Valid),   32'd0);
    check("rst_tag",     32'(bus.Qi_CDB),      32'd0);
    check("rst_data",    32'(bus.Qi_CDB_data), 32'hFFF0);
    check("rst_fin",     32'(bus.Finished),    32'd0);
    check("rst_pending", 32'(bus.Pending),     32'd0);
    check("rst_tagerr",  32'(bus.Tag_Err),     32'd0);
    mon_en = 1'b1;

    // Single result: Ack in t, broadcast in t+2, idle again in t+3.
    cyc(2'b01, 4'd1, 16'h0005, 4'd0, 16'd0, 2'b01, 1'b1);
    check("t1_pending", 32'(bus.Pending), 32'd1);
    idle(1);
    check("t1_valid_t2", 32'(bus.CDB_Valid), 32'd1);
    idle(1);
    check("t1_valid_t3", 32'(bus.CDB_Valid), 32'd0);

    // Simultaneous requests: tag1 then tag2, Pending 2 -> 1 -> 0.
    reset_dut();
    cyc(2'b11, 4'd1, 16'h0011, 4'd2, 16'h0022, 2'b11, 1'b1);
    check("t2_pend2", 32'(bus.Pending), 32'd2);
    idle(1);
    check("t2_pend1", 32'(bus.Pending), 32'd1);
    check("t2_valid_a", 32'(bus.CDB_Valid), 32'd1);
    idle(1);
    check("t2_pend0", 32'(bus.Pending), 32'd0);
    check("t2_valid_b", 32'(bus.CDB_Valid), 32'd1);
    idle(1);
    check("t2_valid_end", 32'(bus.CDB_Valid), 32'd0);

    // Streaming through a single slot with bypass refill.
    reset_dut();
    cyc(2'b01, 4'd1, 16'h0001, 4'd0, 16'd0, 2'b01, 1'b1);
    cyc(2'b01, 4'd1, 16'h0002, 4'd0, 16'd0, 2'b01, 1'b1);
    check("t3_valid_0", 32'(bus.CDB_Valid), 32'd1);
    cyc(2'b01, 4'd1, 16'h0003, 4'd0, 16'd0, 2'b01, 1'b1);
    check("t3_valid_1", 32'(bus.CDB_Valid), 32'd1);
    check("t3_pending", 32'(bus.Pending), 32'd1);
    idle(1);
    check("t3_valid_2", 32'(bus.CDB_Valid), 32'd1);
    idle(1);
    check("t3_valid_end", 32'(bus.CDB_Valid), 32'd0);

    // Fairness: both saturated; after the first cycle acks alternate.
    reset_dut();
    na = 0;
    nb = 0;
    for (int k = 0; k < 8; k++) begin
      ea = (k == 0) ? 2'b11 : ((k % 2 == 1) ? 2'b01 : 2'b10);
      cyc(2'b11, 4'd1, 16'(16'h0100 + na), 4'd2, 16'(16'h0200 + nb), ea, 1'b1);
      if (ea[0]) na++;
      if (ea[1]) nb++;
    end
    idle(4);
    check("t4_drained", 32'(q_exp.size()), 32'd0);

    // Invalid tag: never acked, sticky error, nothing broadcast.
    reset_dut();
    cyc(2'b10, 4'd0, 16'd0, 4'd0, 16'h0099, 2'b00, 1'b1);
    check("t5_tagerr_set", 32'(bus.Tag_Err), 32'd1);
    idle(3);
    check("t5_tagerr_hold", 32'(bus.Tag_Err), 32'd1);
    check("t5_pending", 32'(bus.Pending), 32'd0);
    reset_dut();
    check("t5_tagerr_clr", 32'(bus.Tag_Err), 32'd0);

    // Reset mid-operation drops both held results.
    cyc(2'b11, 4'd1, 16'h00AA, 4'd2, 16'h00BB, 2'b11, 1'b0);
    check("t6_pend_full", 32'(bus.Pending), 32'd2);
    Reset = 1'b1;
    cyc(2'b11, 4'd1, 16'h00CC, 4'd2, 16'h00DD, 2'b00, 1'b0);
    Reset = 1'b0;
    check("t6_valid", 32'(bus.CDB_Valid), 32'd0);
    check("t6_pending", 32'(bus.Pending), 32'd0);
    check("t6_fin", 32'(bus.Finished), 32'd0);
    idle(3);

    check("queue_empty", 32'(q_exp.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
